// File: rtl/key_move_encoder.sv
// key_move_encoder
//   Turns four debounced direction keys into single move commands with a
//   valid/ready handshake and keyboard-style auto-repeat. Only one command
//   is outstanding at a time. Simultaneous presses resolve by the priority
//   up > down > left > right.
//
//   The first repeat comes REPEAT_DLY cycles after the accept of the initial
//   command. Later repeats follow every REPEAT_PER cycles after each accept.
//   Keys other than the latched one are ignored until the latched key is
//   released.
//
// Parameters
//   REPEAT_DLY : cycles from the first accept to the first repeat (2..2^CW-1)
//   REPEAT_PER : cycles between later repeats                     (2..2^CW-1)
//   CW         : width of the repeat counter
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   clr        : asynchronous active-low reset
//   btn_up, btn_down, btn_left, btn_right : key levels, 1 = pressed
//   cmd_ready  : consumer accepts the pending command this cycle
//   cmd_valid  : a move command is pending (registered)
//   cmd_dir    : 00 up, 01 down, 10 left, 11 right (registered)
//   key_held   : high whenever the encoder is not idle (registered)
module key_move_encoder #(
  parameter int unsigned REPEAT_DLY = 25000000,
  parameter int unsigned REPEAT_PER = 5000000,
  parameter int unsigned CW         = 25
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [1:0] cmd_dir,
  output logic       key_held
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DLY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PER - 1);

  state_t        state;
  logic          rep;
  logic [CW-1:0] cnt;

  logic          any_key;
  logic [1:0]    prio_dir;
  logic          latched_key;
  logic [CW-1:0] cnt_last;

  // Priority encoder for a fresh press in IDLE.
  always_comb begin
    any_key  = btn_up | btn_down | btn_left | btn_right;
    prio_dir = 2'b00;
    if (btn_up)
      prio_dir = 2'b00;
    else if (btn_down)
      prio_dir = 2'b01;
    else if (btn_left)
      prio_dir = 2'b10;
    else
      prio_dir = 2'b11;
  end

  // Current level of the key whose code is latched in cmd_dir.
  always_comb begin
    latched_key = 1'b0;
    case (cmd_dir)
      2'b00:   latched_key = btn_up;
      2'b01:   latched_key = btn_down;
      2'b10:   latched_key = btn_left;
      default: latched_key = btn_right;
    endcase
  end

  // The terminal count depends on whether the first delay has elapsed.
  always_comb begin
    cnt_last = rep ? PER_LAST : DLY_LAST;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      rep       <= 1'b0;
      cnt       <= '0;
      cmd_valid <= 1'b0;
      cmd_dir   <= 2'b00;
      key_held  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_key) begin
            cmd_dir   <= prio_dir;
            cmd_valid <= 1'b1;
            key_held  <= 1'b1;
            state     <= PEND;
          end
        end

        PEND: begin
          // Direction is frozen; keys are ignored until the command is taken.
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            cnt       <= '0;
            state     <= HOLD;
          end
        end

        HOLD: begin
          // A release wins over a repeat landing on the same edge.
          if (!latched_key) begin
            rep      <= 1'b0;
            cnt      <= '0;
            key_held <= 1'b0;
            state    <= IDLE;
          end else if (cnt == cnt_last) begin
            cmd_valid <= 1'b1;
            rep       <= 1'b1;
            cnt       <= '0;
            state     <= PEND;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          rep       <= 1'b0;
          cnt       <= '0;
          cmd_valid <= 1'b0;
          key_held  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_move_encoder.sv
module tb_key_move_encoder;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [1:0] cmd_dir;
  logic       key_held;

  int checks = 0;
  int failures = 0;

  key_move_encoder #(
    .REPEAT_DLY(8),
    .REPEAT_PER(4),
    .CW(8)
  ) dut (
    .clk(clk),
    .clr(clr),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd_dir(cmd_dir),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  // One row = inputs applied for one rising edge, outputs expected after it.
  typedef struct {
    logic       u, d, l, r, rdy;
    logic       v;
    logic [1:0] dir;
    logic       held;
  } vec_t;

  vec_t tbl[$];

  task automatic vec(input logic u, d, l, r, rdy, v, input logic [1:0] dir, input logic held);
    vec_t e;
    e.u = u; e.d = d; e.l = l; e.r = r; e.rdy = rdy;
    e.v = v; e.dir = dir; e.held = held;
    tbl.push_back(e);
  endtask

  task automatic check(input string name, input int idx, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%b expected=%b", name, idx, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int idx, input logic v, input logic [1:0] dir, input logic held);
    check({tag, "_valid"}, idx, {1'b0, cmd_valid}, {1'b0, v});
    check({tag, "_dir"},   idx, cmd_dir, dir);
    check({tag, "_held"},  idx, {1'b0, key_held}, {1'b0, held});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Single tap, left, ready tied high.
    vec(0,0,1,0,1, 1,2'b10,1);
    vec(0,0,1,0,1, 0,2'b10,1);
    vec(0,0,1,0,1, 0,2'b10,1);
    vec(0,0,0,0,1, 0,2'b10,0);
    vec(0,0,0,0,1, 0,2'b10,0);
    vec(0,0,0,0,1, 0,2'b10,0);
    // Stall: down held 2 cycles, ready low 10 cycles.
    vec(0,1,0,0,0, 1,2'b01,1);
    vec(0,1,0,0,0, 1,2'b01,1);
    for (int i = 0; i < 8; i++) vec(0,0,0,0,0, 1,2'b01,1);
    vec(0,0,0,0,1, 0,2'b01,1);
    vec(0,0,0,0,1, 0,2'b01,0);
    vec(0,0,0,0,1, 0,2'b01,0);
    // Priority up over right, then swap to right.
    vec(1,0,0,1,1, 1,2'b00,1);
    vec(1,0,0,1,1, 0,2'b00,1);
    vec(1,0,0,1,1, 0,2'b00,1);
    vec(0,0,0,1,1, 0,2'b00,0);
    vec(0,0,0,1,1, 1,2'b11,1);
    vec(0,0,0,1,1, 0,2'b11,1);
    vec(0,0,0,0,1, 0,2'b11,0);
    vec(0,0,0,0,1, 0,2'b11,0);
    // Release race at cnt == REPEAT_DLY-1.
    vec(0,0,1,0,1, 1,2'b10,1);
    vec(0,0,1,0,1, 0,2'b10,1);
    for (int i = 0; i < 7; i++) vec(0,0,1,0,1, 0,2'b10,1);
    vec(0,0,0,0,1, 0,2'b10,0);
    vec(0,0,0,0,1, 0,2'b10,0);
    // Auto-repeat with right held; stray up press and idle ready ignored in HOLD.
    vec(0,0,0,1,1, 1,2'b11,1);
    vec(0,0,0,1,1, 0,2'b11,1);
    for (int i = 0; i < 7; i++) vec(i < 3, 0,0,1, i != 4, 0,2'b11,1);
    vec(0,0,0,1,1, 1,2'b11,1);
    vec(0,0,0,1,1, 0,2'b11,1);
    for (int i = 0; i < 3; i++) vec(0,0,0,1,1, 0,2'b11,1);
    vec(0,0,0,1,1, 1,2'b11,1);
    vec(0,0,0,1,1, 0,2'b11,1);
    for (int i = 0; i < 3; i++) vec(0,0,0,1,1, 0,2'b11,1);
    vec(0,0,0,1,1, 1,2'b11,1);
    vec(0,0,0,1,1, 0,2'b11,1);
    vec(0,0,0,0,1, 0,2'b11,0);
    vec(0,0,0,0,1, 0,2'b11,0);

    // Reset state, and no command on reset release with no key pressed.
    #2;
    check_outs("reset", 0, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_outs("post_reset_idle", 0, 1'b0, 2'b00, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      btn_up    = tbl[i].u;
      btn_down  = tbl[i].d;
      btn_left  = tbl[i].l;
      btn_right = tbl[i].r;
      cmd_ready = tbl[i].rdy;
      @(negedge clk);
      check_outs("vec", i, tbl[i].v, tbl[i].dir, tbl[i].held);
    end

    // Asynchronous reset while a command is pending, up held through release.
    btn_up = 1'b1;
    cmd_ready = 1'b0;
    @(negedge clk);
    check_outs("rst_pend", 0, 1'b1, 2'b00, 1'b1);
    @(negedge clk);
    btn_up = 1'b1;
    btn_right = 1'b1;
    @(negedge clk);
    check_outs("rst_pend", 1, 1'b1, 2'b00, 1'b1);
    #2;
    clr = 1'b0;
    #1;
    check_outs("rst_async", 0, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    check_outs("rst_async", 1, 1'b0, 2'b00, 1'b0);
    btn_right = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    check_outs("rst_fresh", 0, 1'b1, 2'b00, 1'b1);
    cmd_ready = 1'b1;
    @(negedge clk);
    check_outs("rst_fresh", 1, 1'b0, 2'b00, 1'b1);
    btn_up = 1'b0;
    @(negedge clk);
    check_outs("rst_fresh", 2, 1'b0, 2'b00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
